// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the control-unit strobes, datapath bus, board I/O and external SRAM
// pins of the LC-3 memory stage.
//   master : control unit / bench side (drives strobes, bus, switches, DQ_in)
//   slave  : mem_access_unit side (drives SRAM pins, MAR/MDR, status)
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
    // control unit -> memory stage
    logic        LD_MAR;
    logic        LD_MDR;
    logic        Mem_OE;        // active-low read request
    logic        Mem_WE;        // active-low write request
    logic [15:0] Bus;
    logic [15:0] Switches;
    logic [15:0] Sram_DQ_in;

    // memory stage -> SRAM / datapath / control unit
    logic [15:0] Sram_DQ_out;
    logic        Sram_DQ_oe;
    logic [19:0] Sram_ADDR;
    logic        Sram_CE_N;
    logic        Sram_OE_N;
    logic        Sram_WE_N;
    logic        Sram_UB_N;
    logic        Sram_LB_N;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] Hex_out;
    logic        Mem_busy;
    logic        Rd_valid;
    logic        Mem_done;

    modport master (
        output LD_MAR, LD_MDR, Mem_OE, Mem_WE, Bus, Switches, Sram_DQ_in,
        input  Sram_DQ_out, Sram_DQ_oe, Sram_ADDR, Sram_CE_N, Sram_OE_N,
               Sram_WE_N, Sram_UB_N, Sram_LB_N, MAR, MDR, Hex_out,
               Mem_busy, Rd_valid, Mem_done
    );

    modport slave (
        input  LD_MAR, LD_MDR, Mem_OE, Mem_WE, Bus, Switches, Sram_DQ_in,
        output Sram_DQ_out, Sram_DQ_oe, Sram_ADDR, Sram_CE_N, Sram_OE_N,
               Sram_WE_N, Sram_UB_N, Sram_LB_N, MAR, MDR, Hex_out,
               Mem_busy, Rd_valid, Mem_done
    );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// LC-3 memory stage: holds MAR/MDR, turns the control unit's active-low
// Mem_OE/Mem_WE requests into sequenced SRAM read/write cycles, and decodes
// the memory-mapped I/O word at IO_ADDR (reads = switches, writes = hex reg).
// Ports:
//   Clk    rising-edge clock
//   Reset  synchronous, active-high
//   mif    mem_access_unit_if.slave (strobes, bus, SRAM pins, MAR/MDR,
//          Hex_out, Mem_busy/Rd_valid/Mem_done status)
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int          WAIT_CYCLES = 1,        // 1..7
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input logic              Clk,
    input logic              Reset,
    mem_access_unit_if.slave mif
);

    localparam logic [2:0] RD_SETTLE  = 3'(WAIT_CYCLES);
    localparam logic [2:0] PULSE_LAST = 3'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        WR_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  wr_cnt_q, wr_cnt_d;
    logic [2:0]  rd_cnt_q, rd_cnt_d;
    logic [15:0] mar_q, mdr_q, hex_q, dq_out_q, addr_q;

    logic        is_io;
    logic        rd_active;
    logic        sram_rd;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        we_n;
    logic        done;
    logic        wr_start;
    logic        io_wr;

    assign is_io     = (mar_q == IO_ADDR);
    assign mem_rdata = is_io ? mif.Switches : mif.Sram_DQ_in;

    // A read is only honoured with the write FSM idle and no write request,
    // so OE_N can never overlap a cycle in which DQ is driven.
    assign rd_active = !mif.Mem_OE && mif.Mem_WE && (state_q == IDLE);
    assign sram_rd   = rd_active && !is_io;

    // Read settle counter: restarts whenever the request drops or the
    // address is about to change, saturates at the settle count.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (mif.Mem_OE || (mif.LD_MAR && (mif.Bus != mar_q))) begin
            rd_cnt_d = 3'd0;
        end else if (rd_cnt_q < RD_SETTLE) begin
            rd_cnt_d = rd_cnt_q + 3'd1;
        end
    end

    // Write FSM next-state and strobe decode
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        busy     = 1'b0;
        we_n     = 1'b1;
        done     = 1'b0;
        wr_start = 1'b0;
        io_wr    = 1'b0;
        case (state_q)
            IDLE: begin
                wr_cnt_d = 3'd0;
                if (!mif.Mem_WE) begin
                    if (is_io) begin
                        io_wr   = 1'b1;
                        done    = 1'b1;
                        state_d = WR_DONE;
                    end else begin
                        wr_start = 1'b1;
                        state_d  = WR_SETUP;
                    end
                end
            end
            WR_SETUP: begin
                busy     = 1'b1;
                wr_cnt_d = 3'd0;
                state_d  = WR_PULSE;
            end
            WR_PULSE: begin
                busy = 1'b1;
                we_n = 1'b0;
                if (wr_cnt_q == PULSE_LAST) begin
                    state_d = WR_HOLD;
                end else begin
                    wr_cnt_d = wr_cnt_q + 3'd1;
                end
            end
            WR_HOLD: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = WR_DONE;
            end
            WR_DONE: begin
                // Wait for the request to drop so a held-low Mem_WE
                // cannot start a second write.
                if (mif.Mem_WE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            wr_cnt_q <= 3'd0;
            rd_cnt_q <= 3'd0;
            mar_q    <= 16'h0000;
            mdr_q    <= 16'h0000;
            hex_q    <= 16'h0000;
            dq_out_q <= 16'h0000;
            addr_q   <= 16'h0000;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            if (mif.LD_MAR) begin
                mar_q <= mif.Bus;
            end
            if (mif.LD_MDR) begin
                mdr_q <= !mif.Mem_OE ? mem_rdata : mif.Bus;
            end
            // Address and data are frozen for the whole SRAM write so later
            // MAR/MDR loads cannot disturb the cycle in flight.
            if (wr_start) begin
                addr_q   <= mar_q;
                dq_out_q <= mdr_q;
            end
            if (io_wr) begin
                hex_q <= mdr_q;
            end
        end
    end

    assign mif.MAR         = mar_q;
    assign mif.MDR         = mdr_q;
    assign mif.Hex_out     = hex_q;
    assign mif.Sram_DQ_out = dq_out_q;
    assign mif.Sram_DQ_oe  = busy;
    assign mif.Sram_ADDR   = {4'b0000, busy ? addr_q : mar_q};
    assign mif.Sram_CE_N   = !(busy || sram_rd);
    assign mif.Sram_OE_N   = !sram_rd;
    assign mif.Sram_WE_N   = we_n;
    assign mif.Sram_UB_N   = 1'b0;
    assign mif.Sram_LB_N   = 1'b0;
    assign mif.Mem_busy    = busy;
    assign mif.Rd_valid    = rd_active && (is_io || (rd_cnt_q >= RD_SETTLE));
    // Suppressed under reset so an aborted write never reports completion.
    assign mif.Mem_done    = done && !Reset;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed and randomized bench for mem_access_unit. A behavioural SRAM array
// answers the DUT's pins; a transaction-level reference (expected memory
// contents, expected hex register, expected latencies) supplies every
// expected value. A second instance with WAIT_CYCLES=3 covers the longer
// pulse and settle timing.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int          W1 = 1;
    localparam int          W3 = 3;
    localparam logic [15:0] IO = 16'hFFFF;

    logic clk;
    logic rst1;
    logic rst3;

    int checks = 0;
    int errors = 0;

    mem_access_unit_if mif ();
    mem_access_unit_if mif3 ();

    mem_access_unit #(.WAIT_CYCLES(W1), .IO_ADDR(IO)) dut1 (
        .Clk(clk), .Reset(rst1), .mif(mif)
    );
    mem_access_unit #(.WAIT_CYCLES(W3), .IO_ADDR(IO)) dut3 (
        .Clk(clk), .Reset(rst3), .mif(mif3)
    );

    // second instance sees exactly the same control inputs
    assign mif3.LD_MAR     = mif.LD_MAR;
    assign mif3.LD_MDR     = mif.LD_MDR;
    assign mif3.Mem_OE     = mif.Mem_OE;
    assign mif3.Mem_WE     = mif.Mem_WE;
    assign mif3.Bus        = mif.Bus;
    assign mif3.Switches   = mif.Switches;
    assign mif3.Sram_DQ_in = mif.Sram_DQ_in;

    // behavioural SRAM attached to dut1
    logic [15:0] sram [0:65535];
    logic        use_model;
    logic [15:0] dq_force;

    assign mif.Sram_DQ_in = !use_model ? dq_force :
                            (!mif.Sram_OE_N && !mif.Sram_CE_N) ? sram[mif.Sram_ADDR[15:0]] :
                            16'h0BAD;

    always @(posedge clk) begin
        if (!mif.Sram_CE_N && !mif.Sram_WE_N && mif.Sram_DQ_oe)
            sram[mif.Sram_ADDR[15:0]] <= mif.Sram_DQ_out;
    end

    // reference model state
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ref_hex;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // read and output-drive must never coincide
    always @(negedge clk) begin
        if (!rst1)
            chk("oe_dq_overlap", {31'b0, (!mif.Sram_OE_N && mif.Sram_DQ_oe)}, 32'd0);
    end

    task automatic load_regs(input logic [15:0] a, input logic [15:0] d);
        mif.Bus = a; mif.LD_MAR = 1'b1;
        tick();
        mif.LD_MAR = 1'b0; mif.Bus = d; mif.LD_MDR = 1'b1;
        tick();
        mif.LD_MDR = 1'b0;
    endtask

    // One write transaction on dut1, checking strobe counts and latency.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        bit io;
        int we_lo, oe_cyc, done_at, ndone;
        bit bad;
        io = (a == IO);
        we_lo = 0; oe_cyc = 0; done_at = -1; ndone = 0; bad = 0;
        load_regs(a, d);
        mif.Mem_WE = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (!mif.Sram_WE_N) we_lo++;
            if (mif.Sram_DQ_oe) begin
                oe_cyc++;
                if (mif.Sram_DQ_out !== d || mif.Sram_ADDR !== {4'b0, a} || mif.Sram_CE_N !== 1'b0)
                    bad = 1;
            end
            if (mif.Mem_done) begin
                if (done_at < 0) done_at = c;
                ndone++;
            end
            tick();
        end
        mif.Mem_WE = 1'b1;
        tick();
        if (io) ref_hex = d;
        else    ref_mem[a] = d;
        chk(io ? "io_wr_we_low" : "wr_we_low", 32'(we_lo), io ? 32'd0 : 32'(W1));
        chk(io ? "io_wr_dq_oe" : "wr_dq_oe", 32'(oe_cyc), io ? 32'd0 : 32'(W1 + 2));
        chk(io ? "io_wr_done_at" : "wr_done_at", 32'(done_at), io ? 32'd0 : 32'(W1 + 2));
        chk("wr_done_count", 32'(ndone), 32'd1);
        chk("wr_addr_data", {31'b0, bad}, 32'd0);
        chk("hex_out", {16'h0, mif.Hex_out}, {16'h0, ref_hex});
    endtask

    // One read transaction on dut1; MDR loaded on the last request cycle.
    task automatic do_read(input logic [15:0] a, input logic [15:0] exp_d);
        bit io;
        bit bad;
        io = (a == IO);
        bad = 0;
        mif.Bus = a; mif.LD_MAR = 1'b1;
        tick();
        mif.LD_MAR = 1'b0;
        mif.Mem_OE = 1'b0;
        for (int c = 0; c <= W1; c++) begin
            if (c == W1) mif.LD_MDR = 1'b1;
            #1;
            if (mif.Rd_valid !== (io || c >= W1)) bad = 1;
            if (mif.Sram_OE_N !== io || mif.Sram_CE_N !== io) bad = 1;
            if (!io && mif.Sram_ADDR !== {4'b0, a}) bad = 1;
            tick();
        end
        mif.Mem_OE = 1'b1;
        mif.LD_MDR = 1'b0;
        #1;
        chk(io ? "io_rd_strobes" : "rd_strobes", {31'b0, bad}, 32'd0);
        chk(io ? "io_rd_mdr" : "rd_mdr", {16'h0, mif.MDR}, {16'h0, exp_d});
    endtask

    initial begin
        logic [15:0] a, d;
        int op;
        int we_lo, done_at, ndone;

        rst1 = 1'b1; rst3 = 1'b1;
        mif.LD_MAR = 1'b0; mif.LD_MDR = 1'b0;
        mif.Mem_OE = 1'b1; mif.Mem_WE = 1'b1;
        mif.Bus = 16'h0; mif.Switches = 16'h0;
        use_model = 1'b1; dq_force = 16'h0;
        ref_hex = 16'h0;

        // reset and idle
        tick(); tick();
        rst1 = 1'b0;
        #1;
        chk("rst_mar", {16'h0, mif.MAR}, 32'h0);
        chk("rst_mdr", {16'h0, mif.MDR}, 32'h0);
        chk("rst_hex", {16'h0, mif.Hex_out}, 32'h0);
        chk("rst_dq_out", {16'h0, mif.Sram_DQ_out}, 32'h0);
        chk("rst_addr", {12'h0, mif.Sram_ADDR}, 32'h0);
        chk("rst_strobes", {27'h0, mif.Sram_CE_N, mif.Sram_OE_N, mif.Sram_WE_N,
                            mif.Sram_UB_N, mif.Sram_LB_N}, 32'b11100);
        chk("rst_status", {28'h0, mif.Sram_DQ_oe, mif.Mem_busy, mif.Rd_valid, mif.Mem_done}, 32'h0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_we_oe", {30'h0, mif.Sram_WE_N, mif.Sram_DQ_oe}, 32'b10);
        end

        // directed SRAM read from a forced data bus
        use_model = 1'b0; dq_force = 16'hBEEF;
        do_read(16'h0042, 16'hBEEF);
        use_model = 1'b1;

        // directed SRAM write, then I/O read and write
        do_write(16'h1234, 16'hA5A5);
        chk("wr_dq_out_kept", {16'h0, mif.Sram_DQ_out}, 32'hA5A5);
        chk("wr_sram_content", {16'h0, sram[16'h1234]}, 32'hA5A5);
        mif.Switches = 16'h00C3;
        do_read(IO, 16'h00C3);
        do_write(IO, 16'h7E01);

        // MAR reload mid-write with simultaneous read request
        load_regs(16'h2222, 16'h1111);
        mif.Mem_WE = 1'b0; mif.Mem_OE = 1'b0;
        #1;
        chk("both_low_oe_n", {30'h0, mif.Sram_OE_N, mif.Rd_valid}, 32'b10);
        tick();
        chk("both_low_setup_oe_n", {31'h0, mif.Sram_OE_N}, 32'h1);
        tick();
        mif.Bus = 16'h5555; mif.LD_MAR = 1'b1;
        #1;
        chk("mid_pulse_addr", {12'h0, mif.Sram_ADDR}, 32'h02222);
        chk("mid_pulse_we_n", {31'h0, mif.Sram_WE_N}, 32'h0);
        tick();
        mif.LD_MAR = 1'b0;
        #1;
        chk("mid_hold_addr", {12'h0, mif.Sram_ADDR}, 32'h02222);
        chk("mid_hold_mar", {16'h0, mif.MAR}, 32'h5555);
        tick();
        mif.Mem_WE = 1'b1; mif.Mem_OE = 1'b1;
        tick();
        chk("mid_sram_content", {16'h0, sram[16'h2222]}, 32'h1111);

        // reset during the write pulse
        load_regs(16'h3000, 16'h0F0F);
        mif.Mem_WE = 1'b0;
        tick(); tick();
        chk("rst_wr_in_pulse", {31'h0, mif.Sram_WE_N}, 32'h0);
        rst1 = 1'b1;
        #1;
        chk("rst_wr_no_done_now", {31'h0, mif.Mem_done}, 32'h0);
        tick();
        chk("rst_wr_next_edge", {29'h0, mif.Sram_WE_N, mif.Sram_DQ_oe, mif.Mem_busy}, 32'b100);
        chk("rst_wr_no_done", {31'h0, mif.Mem_done}, 32'h0);
        rst1 = 1'b0; mif.Mem_WE = 1'b1;
        ref_hex = 16'h0;
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (mif.Mem_done) ndone++;
            tick();
        end
        chk("rst_wr_no_late_done", 32'(ndone), 32'd0);

        // randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            a  = 16'h0100 + 16'($urandom_range(0, 7));
            d  = 16'($urandom);
            case (op)
                0: do_write(a, d);
                1: if (ref_mem.exists(a)) do_read(a, ref_mem[a]);
                   else                  do_write(a, d);
                2: do_write(IO, d);
                default: begin
                    mif.Switches = d;
                    do_read(IO, d);
                end
            endcase
        end

        // WAIT_CYCLES=3 instance
        rst1 = 1'b1;
        tick();
        rst3 = 1'b0;
        #1;
        chk("w3_rst", {15'h0, mif3.MAR, mif3.Mem_busy}, 32'h0);
        mif.Bus = 16'h0200; mif.LD_MAR = 1'b1;
        tick();
        mif.LD_MAR = 1'b0; mif.Mem_OE = 1'b0;
        for (int c = 0; c <= W3; c++) begin
            #1;
            chk("w3_rd_valid", {31'h0, mif3.Rd_valid}, {31'h0, (c >= W3)});
            tick();
        end
        mif.Mem_OE = 1'b1;
        mif.Bus = 16'h3333; mif.LD_MAR = 1'b1;
        tick();
        mif.LD_MAR = 1'b0; mif.Bus = 16'hCAFE; mif.LD_MDR = 1'b1;
        tick();
        mif.LD_MDR = 1'b0;
        mif.Mem_WE = 1'b0;
        we_lo = 0; done_at = -1; ndone = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (!mif3.Sram_WE_N) we_lo++;
            if (mif3.Mem_done) begin
                if (done_at < 0) done_at = c;
                ndone++;
            end
            tick();
        end
        mif.Mem_WE = 1'b1;
        tick();
        chk("w3_we_low", 32'(we_lo), 32'(W3));
        chk("w3_done_at", 32'(done_at), 32'(W3 + 2));
        chk("w3_done_count", 32'(ndone), 32'd1);
        chk("w3_dq_out", {16'h0, mif3.Sram_DQ_out}, 32'hCAFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Datapath memory stage directly downstream of the LC-3 control unit.
- Holds MAR and MDR and converts the control unit's active-low Mem_OE/Mem_WE strobes into correctly sequenced external SRAM read/write cycles.
- Decodes memory-mapped I/O at 16'hFFFF: reads return the board switches; writes latch the hex-display register.
- Reports access progress (Mem_busy, Rd_valid, Mem_done) so fixed-length memory states can be checked against real SRAM timing.

Parameters:
- WAIT_CYCLES, 1, number of cycles Sram_WE_N is held low per write and read-settle cycles before Rd_valid (legal range 1..7).
- IO_ADDR, 16'hFFFF, memory-mapped I/O address.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  synchronous, active-high.
- LD_MAR  in  1  MAR <= Bus at clock edge.
- LD_MDR  in  1  MDR <= selected source at clock edge.
- Mem_OE  in  1  active-low read request from control unit.
- Mem_WE  in  1  active-low write request from control unit.
- Bus  in  16  internal datapath bus.
- Switches  in  16  board switch value (I/O read data).
- Sram_DQ_in  in  16  SRAM data pins, read side.
- Sram_DQ_out  out  16  SRAM data pins, write side.
- Sram_DQ_oe  out  1  1 = drive Sram_DQ_out onto pins.
- Sram_ADDR  out  20  SRAM address, {4'b0, access address}.
- Sram_CE_N, Sram_OE_N, Sram_WE_N, Sram_UB_N, Sram_LB_N  out  1 each  SRAM strobes, active-low.
- MAR  out  16  memory address register.
- MDR  out  16  memory data register.
- Hex_out  out  16  I/O display register.
- Mem_busy  out  1  write sequence in progress.
- Rd_valid  out  1  read data settled.
- Mem_done  out  1  one-cycle pulse at write completion.

Behaviour:
- Reset values:
  - MAR, MDR, Hex_out, Sram_DQ_out = 0; Sram_ADDR = 0.
  - Sram_CE_N/OE_N/WE_N = 1; Sram_DQ_oe = 0; Mem_busy = Rd_valid = Mem_done = 0.
  - Write FSM in IDLE; counters cleared.
- Sram_UB_N = Sram_LB_N = 0 always (16-bit accesses only).
- Reset mid-write: WE_N high and DQ_oe low on the very next edge; no partial completion pulse.
- MAR:
  - MAR <= Bus when LD_MAR=1, in any state.
  - Active writes use addr_q, latched at write start, so MAR changes mid-write do not alter Sram_ADDR.
- Read path:
  - mem_rdata = (MAR==IO_ADDR) ? Switches : Sram_DQ_in.
  - MDR <= (Mem_OE==0) ? mem_rdata : Bus when LD_MDR=1.
  - Sram_OE_N = 0 and Sram_CE_N = 0 iff Mem_OE=0, Mem_WE=1, FSM in IDLE, and MAR != IO_ADDR.
  - Sram_ADDR = {4'b0, MAR} while reading.
  - Read counter increments each cycle Mem_OE=0; it clears when Mem_OE=1 or MAR changes.
  - Rd_valid = 1 once the counter reaches WAIT_CYCLES. For I/O reads, Rd_valid = 1 from the first cycle.
- Write FSM states: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, WR_DONE.
  - IDLE -> WR_SETUP:
    - Trigger: Mem_WE=0 and MAR != IO_ADDR.
    - Latches addr_q <= MAR and Sram_DQ_out <= MDR.
  - I/O write in IDLE:
    - Trigger: Mem_WE=0 and MAR == IO_ADDR.
    - Hex_out <= MDR; go directly to WR_DONE; Mem_done pulses in that cycle.
  - WR_SETUP, 1 cycle: CE_N=0, DQ_oe=1, WE_N=1.
  - WR_PULSE, WAIT_CYCLES cycles (counted): CE_N=0, DQ_oe=1, WE_N=0.
  - WR_HOLD, 1 cycle: CE_N=0, DQ_oe=1, WE_N=1. Then go to WR_DONE; Mem_done=1 for exactly one cycle on entry.
  - WR_DONE: all strobes inactive; stays until Mem_WE=1, then IDLE. A held-low Mem_WE never causes a second write.
  - Mem_busy = 1 in WR_SETUP, WR_PULSE, WR_HOLD.
  - SRAM write latency (Mem_WE low to Mem_done) = WAIT_CYCLES+2 cycles.
- Simultaneous Mem_OE=0 and Mem_WE=0: write has priority; Sram_OE_N stays 1 (no bus contention); Rd_valid = 0.
- Sram_OE_N and Sram_DQ_oe are never both active in the same cycle.

Test Plan:
- Reset, then idle: all outputs at reset values; Sram_WE_N=1, Sram_DQ_oe=0 for 10 cycles.
- SRAM read: Bus=16'h0042 with LD_MAR; Mem_OE low for 2 cycles; LD_MDR on 2nd cycle with Sram_DQ_in=16'hBEEF -> Sram_ADDR=20'h00042, OE_N low both cycles, Rd_valid high on cycle 2 (WAIT_CYCLES=1), MDR=16'hBEEF.
- SRAM write: MAR=16'h1234, MDR=16'hA5A5, Mem_WE low for 6 cycles -> WE_N low exactly 1 cycle, bracketed by DQ_oe=1 setup/hold cycles, Sram_DQ_out=16'hA5A5, Mem_done single pulse 3 cycles after start, no second write.
- I/O: MAR=16'hFFFF, Switches=16'h00C3, Mem_OE low + LD_MDR -> MDR=16'h00C3, Sram_OE_N stays 1. Then MDR=16'h7E01, Mem_WE low -> Hex_out=16'h7E01, Sram_WE_N never low.
- Change MAR to 16'h5555 during WR_PULSE -> Sram_ADDR stays at the latched address. Mem_OE and Mem_WE low together -> only the write occurs, OE_N=1.
- Reset asserted during WR_PULSE -> next edge WE_N=1, DQ_oe=0, Mem_done never pulses; WAIT_CYCLES=3 rerun -> WE_N low 3 cycles, Mem_done at cycle 5.
